// File: rtl/vga_scandoubler_param_if.sv
// vga_scandoubler_param_if: video-in / VGA-out bundle for the scandoubler.
// Line-count outputs exist only when SCANDBL_LINECOUNT_EN is defined.
interface vga_scandoubler_param_if #(parameter int CW = 3);
    logic          clk_en;
    logic          enable_scandoubling;
    logic [1:0]    scan_mode;
    logic [CW-1:0] ri, gi, bi;
    logic          hsync_ext_n, vsync_ext_n, csync_ext_n;
    logic [CW-1:0] ro, go, bo;
    logic          hsync, vsync;
    logic          line_overflow;
`ifdef SCANDBL_LINECOUNT_EN
    logic [9:0]    lines_per_frame;
    logic          frame_valid;
`endif
    modport master (
`ifdef SCANDBL_LINECOUNT_EN
        input  lines_per_frame, frame_valid,
`endif
        output clk_en, enable_scandoubling, scan_mode, ri, gi, bi,
        output hsync_ext_n, vsync_ext_n, csync_ext_n,
        input  ro, go, bo, hsync, vsync, line_overflow
    );
    modport slave (
`ifdef SCANDBL_LINECOUNT_EN
        output lines_per_frame, frame_valid,
`endif
        input  clk_en, enable_scandoubling, scan_mode, ri, gi, bi,
        input  hsync_ext_n, vsync_ext_n, csync_ext_n,
        output ro, go, bo, hsync, vsync, line_overflow
    );
endinterface

// File: rtl/vga_scandoubler_param.sv
// vga_scandoubler_param: two-bank line buffer replaying each 15 kHz line twice for 31 kHz VGA, with scanline dimming.
// Optional SCANDBL_LINECOUNT_EN adds a per-frame input line counter.
module vga_scandoubler_param #(
    parameter int CW       = 3,
    parameter int ADDR_W   = 10,
    parameter int CLKVIDEO = 14000,
    parameter int HSYNC_NS = 2290,
    parameter int VSYNC_NS = 162860
) (
    input logic clk,
    input logic rst_n,
    vga_scandoubler_param_if.slave bus
);
    localparam longint HS_L = longint'(CLKVIDEO) * longint'(HSYNC_NS) * 2 / 1000000;
    localparam longint VS_L = longint'(CLKVIDEO) * longint'(VSYNC_NS) * 2 / 1000000;
    localparam logic [31:0] HSYNC_COUNT = 32'(HS_L);
    localparam logic [31:0] VSYNC_COUNT = 32'(VS_L);
    localparam logic [ADDR_W-1:0] AMAX = '1;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} vs_t;

    logic [3*CW-1:0] mem [0:2*(2**ADDR_W)-1];
    logic [3*CW-1:0] rdata;
    logic [ADDR_W-1:0] waddr, raddr, totalhor;
    logic wbank, rbank, pass, pass_d;
    logic hs_w_prev, hs_r_prev, hs_vga_n, vs_vga, ovf;
    logic edge_w, edge_r;
    logic [31:0] vcnt;
    vs_t vs_st;
    logic [1:0] sm;
    logic [CW-1:0] ro_q, go_q, bo_q;
    logic hsync_q, vsync_q;

    function automatic logic [CW-1:0] dim(input logic [CW-1:0] x, input logic [1:0] m);
        return m == 2'd1 ? x - (x >> 2) : m == 2'd2 ? x >> 1 : m == 2'd3 ? x >> 2 : x;
    endfunction

    assign edge_w = hs_w_prev & ~bus.hsync_ext_n;
    assign edge_r = hs_r_prev & ~bus.hsync_ext_n;
    assign sm     = pass_d ? bus.scan_mode : 2'b00;

    always_ff @(posedge clk)
        if (bus.clk_en) mem[{wbank, waddr}] <= {bus.ri, bus.gi, bus.bi};

    // Write side: the pixel carrying the hsync edge closes the line it belongs to
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            waddr     <= '0;
            wbank     <= 1'b0;
            totalhor  <= AMAX;
            hs_w_prev <= 1'b1;
            ovf       <= 1'b0;
        end else if (bus.clk_en) begin
            hs_w_prev <= bus.hsync_ext_n;
            if (edge_w) begin
                totalhor <= waddr;
                wbank    <= ~wbank;
                waddr    <= '0;
            end else if (waddr == AMAX) ovf <= 1'b1;
            else waddr <= waddr + 1'b1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            raddr     <= '0;
            rbank     <= 1'b0;
            pass      <= 1'b0;
            hs_r_prev <= 1'b1;
        end else begin
            hs_r_prev <= bus.hsync_ext_n;
            if (edge_r) begin
                raddr <= '0;
                rbank <= wbank;
                pass  <= ~pass;
            end else if (raddr == totalhor) begin
                raddr <= '0;
                pass  <= ~pass;
            end else raddr <= raddr + 1'b1;
        end

    // Sync/pass tags travel alongside the 1-clk RAM read
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rdata    <= '0;
            pass_d   <= 1'b0;
            hs_vga_n <= 1'b1;
        end else begin
            rdata    <= mem[{rbank, raddr}];
            pass_d   <= pass;
            hs_vga_n <= !({{(32-ADDR_W){1'b0}}, raddr} < HSYNC_COUNT);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vs_st  <= IDLE;
            vs_vga <= 1'b1;
            vcnt   <= '0;
        end else if (vs_st == IDLE) begin
            if (!bus.vsync_ext_n) begin
                vs_st  <= PULSE;
                vs_vga <= 1'b0;
                vcnt   <= '0;
            end
        end else if (bus.vsync_ext_n) begin
            vs_st  <= IDLE;
            vs_vga <= 1'b1;
        end else if (vs_st == PULSE) begin
            if (vcnt == VSYNC_COUNT - 32'd1) begin
                vs_st  <= HOLD;
                vs_vga <= 1'b1;
            end else vcnt <= vcnt + 32'd1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ro_q    <= '0;
            go_q    <= '0;
            bo_q    <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (bus.enable_scandoubling) begin
            ro_q    <= dim(rdata[3*CW-1 -: CW], sm);
            go_q    <= dim(rdata[2*CW-1 -: CW], sm);
            bo_q    <= dim(rdata[CW-1:0], sm);
            hsync_q <= hs_vga_n;
            vsync_q <= vs_vga;
        end else begin
            ro_q    <= bus.ri;
            go_q    <= bus.gi;
            bo_q    <= bus.bi;
            hsync_q <= bus.csync_ext_n;
            vsync_q <= 1'b1;
        end

    assign bus.ro            = ro_q;
    assign bus.go            = go_q;
    assign bus.bo            = bo_q;
    assign bus.hsync         = hsync_q;
    assign bus.vsync         = vsync_q;
    assign bus.line_overflow = ovf;

`ifdef SCANDBL_LINECOUNT_EN
    logic [9:0] lcnt, lpf;
    logic fv, vs_prev;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lcnt    <= '0;
            lpf     <= '0;
            fv      <= 1'b0;
            vs_prev <= 1'b1;
        end else begin
            vs_prev <= bus.vsync_ext_n;
            if (vs_prev & ~bus.vsync_ext_n) begin
                lpf  <= lcnt;
                fv   <= 1'b1;
                lcnt <= '0;
            end else if (bus.clk_en & edge_w & (lcnt != 10'h3ff)) lcnt <= lcnt + 10'd1;
        end

    assign bus.lines_per_frame = lpf;
    assign bus.frame_valid     = fv;
`endif
endmodule
